// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone SRAM slave: FSM states,
// termination kinds, legal byte-select codes and a ceil-log2 helper.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TERM_OK  = 2'd0,
    TERM_ERR = 2'd1,
    TERM_RTY = 2'd2
  } term_t;

  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H1 = 4'b1100;
  localparam logic [3:0] SEL_W  = 4'b1111;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Only naturally aligned byte, halfword and word lanes are accepted.
  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_H0, SEL_H1, SEL_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_sram_array.sv
// Word-organised RAM built from four independent byte banks, each with
// its own write enable and a registered, enabled read port.
module wb_sram_array
  import wb_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IW        = clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic [IW-1:0] wr_idx,
  input  logic [3:0]    wr_en,
  input  logic [31:0]   wr_data,
  input  logic [IW-1:0] rd_idx,
  input  logic          rd_en,
  output logic [31:0]   rd_data
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [7:0] bank [MEM_WORDS];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge clk) begin
      if (wr_en[gi]) bank[wr_idx] <= wr_data[gi*8 +: 8];
    end

    // Read register doubles as the bus data output, so it holds between reads.
    always_ff @(posedge clk) begin
      if (srst) rd_byte_reg <= 8'h00;
      else if (rd_en) rd_byte_reg <= bank[rd_idx];
    end

    assign rd_data[gi*8 +: 8] = rd_byte_reg;
  end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone classic-cycle slave in front of an on-chip SRAM, with
// programmable wait states, error decode and retry while the RAM is held.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int             DW          = 32,
  parameter int             AW          = 32,
  parameter int             MEM_WORDS   = 1024,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int             WAIT_STATES = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  output logic [DW-1:0] wb_data_o,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  input  logic          hold_i
);

  localparam int            IW      = clog2(MEM_WORDS);
  localparam logic [AW-1:0] SPAN    = AW'(4 * MEM_WORDS);
  localparam logic [3:0]    WS_LAST = 4'(WAIT_STATES - 1);

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          ack_reg, ack_next;
  logic          err_reg, err_next;
  logic          rty_reg, rty_next;
  logic [IW-1:0] idx_reg;
  logic          we_reg;
  logic [3:0]    sel_reg;
  logic [DW-1:0] data_reg;

  logic          req;
  logic [AW-1:0] offset;
  term_t         req_term;
  logic          latch_en;
  logic          access_en;
  logic [IW-1:0] acc_idx;
  logic          acc_we;
  logic [3:0]    acc_sel;
  logic [DW-1:0] acc_data;

  assign req    = wb_cyc_i & wb_stb_i;
  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset = wb_addr_i - BASE_ADDR;

  always_comb begin
    req_term = TERM_OK;
    if (offset >= SPAN || !sel_legal(wb_sel_i)) req_term = TERM_ERR;
    else if (hold_i)                            req_term = TERM_RTY;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    rty_next   = 1'b0;
    latch_en   = 1'b0;
    access_en  = 1'b0;
    acc_idx    = idx_reg;
    acc_we     = we_reg;
    acc_sel    = sel_reg;
    acc_data   = data_reg;
    case (state_reg)
      ST_IDLE: begin
        // With no wait states the RAM is accessed straight from the bus.
        acc_idx  = offset[IW+1:2];
        acc_we   = wb_we_i;
        acc_sel  = wb_sel_i;
        acc_data = wb_data_i;
        if (req) begin
          latch_en = 1'b1;
          case (req_term)
            TERM_ERR: begin
              err_next   = 1'b1;
              state_next = ST_RESP;
            end
            TERM_RTY: begin
              rty_next   = 1'b1;
              state_next = ST_RESP;
            end
            default: begin
              if (WAIT_STATES == 0) begin
                ack_next   = 1'b1;
                access_en  = 1'b1;
                state_next = ST_RESP;
              end else begin
                cnt_next   = WS_LAST;
                state_next = ST_WAIT;
              end
            end
          endcase
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == 4'd0) begin
          ack_next   = 1'b1;
          access_en  = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rty_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      rty_reg   <= rty_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (latch_en) begin
      idx_reg  <= offset[IW+1:2];
      we_reg   <= wb_we_i;
      sel_reg  <= wb_sel_i;
      data_reg <= wb_data_i;
    end
  end

  wb_sram_array #(
    .MEM_WORDS (MEM_WORDS),
    .IW        (IW)
  ) u_array (
    .clk     (clk_i),
    .srst    (rst_i),
    .wr_idx  (acc_idx),
    .wr_en   ({4{access_en & acc_we & ~rst_i}} & acc_sel),
    .wr_data (acc_data),
    .rd_idx  (acc_idx),
    .rd_en   (access_en & ~acc_we & ~rst_i),
    .rd_data (wb_data_o)
  );

  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;
  assign wb_rty_o = rty_reg;

endmodule
